// File: rtl/dual_edge_gearbox.sv
// Dual-edge capture gearbox: packs each rising/falling sample pair of data_i
// into one 2*WIDTH word and queues it in a show-ahead FIFO with valid/ready drain.
module dual_edge_gearbox #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       en_i,
  input  logic                       clr_i,
  output logic [2*WIDTH-1:0]         data_o,
  output logic [1:0]                 strb_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 2*WIDTH + 2;

  // Handshake: a word moves out at a rising edge where valid_o && ready_i;
  // valid_o never depends on ready_i, and the head stays stable until popped.

  logic [WIDTH-1:0] rise_q, fall_q;
  logic             rv_q, fv_q;

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             ovf_q;

  logic             push_req, full, valid, pop, push, drop;
  logic [EW-1:0]    head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rise_q <= '0;
      rv_q   <= 1'b0;
    end else begin
      rise_q <= en_i ? data_i : '0;
      rv_q   <= en_i;
    end
  end

  always_ff @(negedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      fall_q <= '0;
      fv_q   <= 1'b0;
    end else begin
      fall_q <= en_i ? data_i : '0;
      fv_q   <= en_i;
    end
  end

  // A full FIFO still accepts a push when the head leaves at the same edge.
  always_comb begin
    push_req = rv_q | fv_q;
    full     = (count_q == CW'(DEPTH));
    valid    = (count_q != '0);
    pop      = valid & ready_i & ~clr_i;
    push     = push_req & ~clr_i & (~full | pop);
    drop     = push_req & ~clr_i & full & ~pop;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= {fv_q, rv_q, fall_q, rise_q};
  end

  always_comb begin
    head       = mem[rd_ptr_q];
    data_o     = valid ? head[2*WIDTH-1:0] : '0;
    strb_o     = valid ? head[EW-1:2*WIDTH] : 2'b00;
    valid_o    = valid;
    count_o    = count_q;
    overflow_o = ovf_q;
  end

endmodule

// File: tb/tb_dual_edge_gearbox.sv
// Bench for dual_edge_gearbox: directed beats plus random traffic, checked every
// cycle against a queue-based model of beats, pushes, pops and overflow.
module tb_dual_edge_gearbox;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          arst_n;
  logic [W-1:0]  din;
  logic          en, clr, ready;
  logic [2*W-1:0] dout;
  logic [1:0]    strb;
  logic          valid;
  logic [CW-1:0] count;
  logic          ovf;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_on = 1'b0;

  // Model state: pending half-samples of the current beat and the FIFO as a queue.
  logic [2*W+1:0] exp_q[$];
  logic [W-1:0]   m_rise, m_fall;
  logic           m_rv, m_fv, m_ovf;
  logic [2*W+1:0] m_word, m_tmp;

  logic           e_valid;
  logic [2*W-1:0] e_data;
  logic [1:0]     e_strb;

  dual_edge_gearbox #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk), .arst_ni(arst_n), .data_i(din), .en_i(en), .clr_i(clr),
    .data_o(dout), .strb_o(strb), .valid_o(valid), .ready_i(ready),
    .count_o(count), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rise = '0; m_fall = '0; m_rv = 1'b0; m_fv = 1'b0; m_ovf = 1'b0;
  endtask

  always @(posedge clk) begin
    if (arst_n) begin
      m_word = {m_fv, m_rv, m_fall, m_rise};
      if (clr) begin
        exp_q.delete();
        m_ovf = 1'b0;
      end else begin
        if (exp_q.size() > 0 && ready) m_tmp = exp_q.pop_front();
        if (m_fv || m_rv) begin
          if (exp_q.size() < D) exp_q.push_back(m_word);
          else m_ovf = 1'b1;
        end
      end
      m_rise = en ? din : '0;
      m_rv   = en;
    end
  end

  always @(negedge clk) begin
    if (arst_n) begin
      m_fall = en ? din : '0;
      m_fv   = en;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_on) begin
      e_valid = (exp_q.size() != 0);
      e_data  = e_valid ? exp_q[0][2*W-1:0] : '0;
      e_strb  = e_valid ? exp_q[0][2*W+1:2*W] : 2'b00;
      chk("cyc_valid", valid, e_valid);
      chk("cyc_data",  dout,  e_data);
      chk("cyc_strb",  strb,  e_strb);
      chk("cyc_count", count, exp_q.size());
      chk("cyc_ovf",   ovf,   m_ovf);
    end
  end

  // One beat: rise-edge inputs, then fall-edge inputs; returns just after the fall edge.
  task automatic beat(input logic [W-1:0] rd, input logic re, input logic [W-1:0] fd,
                      input logic fe, input logic rdy, input logic cl);
    din = rd; en = re; ready = rdy; clr = cl;
    @(posedge clk); #2;
    din = fd; en = fe;
    @(negedge clk); #2;
  endtask

  task automatic idle(input logic rdy);
    beat(W'($urandom), 1'b0, W'($urandom), 1'b0, rdy, 1'b0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_data"},  dout,  0);
    chk({name, "_strb"},  strb,  0);
    chk({name, "_valid"}, valid, 0);
    chk({name, "_count"}, count, 0);
    chk({name, "_ovf"},   ovf,   0);
  endtask

  initial begin
    arst_n = 1'b0; din = '0; en = 1'b0; clr = 1'b0; ready = 1'b0;
    model_reset();
    #1;
    chk_all_zero("reset");
    @(negedge clk); #2;
    arst_n = 1'b1;
    cmp_on = 1'b1;

    // Continuous stream
    beat(8'h11, 1, 8'h22, 1, 1, 0);
    chk("stream_latency_valid", valid, 0);
    beat(8'h33, 1, 8'h44, 1, 1, 0);
    chk("stream_w0_data", dout, 16'h2211);
    chk("stream_w0_strb", strb, 2'b11);
    chk("stream_w0_count", count, 1);
    idle(1);
    chk("stream_w1_data", dout, 16'h4433);
    chk("stream_w1_count", count, 1);
    idle(1);
    chk("stream_drained", valid, 0);

    // Half-disabled beats; disabled halves carry nonzero garbage on data_i
    beat(8'hA5, 1, 8'hFF, 0, 0, 0);
    beat(8'hC3, 0, 8'h5A, 1, 0, 0);
    chk("half_rise_data", dout, 16'h00A5);
    chk("half_rise_strb", strb, 2'b01);
    idle(0);
    idle(0);
    chk("idle_beat_no_word", count, 2);
    idle(1);
    chk("half_fall_data", dout, 16'h5A00);
    chk("half_fall_strb", strb, 2'b10);
    chk("half_fall_count", count, 1);
    beat(8'h66, 1, 8'h99, 1, 0, 0);
    idle(0);

    // Async reset while clk is high, count 2
    @(posedge clk); #2;
    chk("pre_reset_count", count, 2);
    arst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #2;
    arst_n = 1'b1; en = 1'b1; din = 8'h77; ready = 1'b0; clr = 1'b0;
    @(negedge clk); #2;
    en = 1'b0; din = W'($urandom);
    @(posedge clk); #2;
    chk("post_reset_strb", strb, 2'b10);
    chk("post_reset_data", dout, 16'h7700);
    chk("post_reset_count", count, 1);
    @(negedge clk); #2;
    idle(1);

    // Backpressure and overflow
    for (int i = 0; i < 5; i++) beat(W'(8'hA0 + i), 1, W'(8'hB0 + i), 1, 0, 0);
    chk("full_no_ovf_yet", ovf, 0);
    idle(0);
    chk("ovf_count", count, 4);
    chk("ovf_flag", ovf, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", dout, {W'(8'hB0 + i), W'(8'hA0 + i)});
      idle(1);
    end
    chk("fifth_absent", valid, 0);
    chk("ovf_sticky", ovf, 1);

    // Clear with count 3 and overflow set
    for (int i = 0; i < 3; i++) beat(W'(8'hC0 + i), 1, W'(8'hD0 + i), 1, 0, 0);
    idle(0);
    chk("pre_clr_count", count, 3);
    beat(8'hE1, 1, 8'hE2, 1, 0, 1);
    chk("clr_count", count, 0);
    chk("clr_valid", valid, 0);
    chk("clr_ovf", ovf, 0);
    idle(0);
    chk("clr_beat_data", dout, 16'hE2E1);
    chk("clr_beat_count", count, 1);
    idle(1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 5; i++) beat(W'(8'h10 + i), 1, W'(8'h20 + i), 1, 0, 0);
    chk("fill_count", count, 4);
    for (int k = 5; k <= 10; k++) begin
      beat(W'(8'h10 + k), 1, W'(8'h20 + k), 1, 1, 0);
      chk("full_pp_count", count, 4);
      chk("full_pp_ovf", ovf, 0);
      chk("full_pp_head", dout, {W'(8'h20 + k - 4), W'(8'h10 + k - 4)});
    end
    repeat (6) idle(1);
    chk("full_pp_drained", count, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      beat(W'($urandom), 1'($urandom_range(0, 3) != 0), W'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
